multi_blinker: RTL and testbench

Parametrised multi-channel successor to the single-output blinker: one phase accumulator per channel, each independently configurable at run time for OFF, ON, BLINK (50 % square wave) or PWM mode. It drives board LEDs and slow status/enable lines from a shared clock. A register-style write port sets mode, rate and duty per channel, and a global sync input re-aligns all channels.

---
 rtl/multi_blinker.sv | 125 ++++++++++++
 tb/tb_multi_blinker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_blinker.sv
// multi_blinker: multi-channel phase-accumulator blinker for LEDs and slow
// status lines. Each channel runs OFF / ON / BLINK / PWM with its own rate.
// Optional feature macro: MULTI_BLINKER_PWM_EN (builds duty registers and the
// PWM mode; without it mode 11 behaves as BLINK and i_wr_duty is ignored).

module multi_blinker_ch #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEFAULT_INC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [1:0]       i_wr_mode,
  input  logic [WIDTH-1:0] i_wr_inc,
  input  logic [7:0]       i_wr_duty,
  output logic             o_out,
  output logic             o_wrap
);
  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;

  logic [WIDTH-1:0] acc, acc_nx, inc, inc_nx, sum;
  logic [1:0]       mode, mode_nx;
  logic             carry, clr, out_nx, wrap_nx;

`ifdef MULTI_BLINKER_PWM_EN
  logic [7:0] duty, duty_nx;
`else
  logic unused_duty;
  assign unused_duty = ^i_wr_duty;
`endif

  // Next config, next accumulator and next outputs; outputs are computed from
  // the post-edge state so they can be registered with no input-to-output path.
  always_comb begin
    mode_nx = i_wr ? i_wr_mode : mode;
    inc_nx  = i_wr ? i_wr_inc  : inc;
`ifdef MULTI_BLINKER_PWM_EN
    duty_nx = i_wr ? i_wr_duty : duty;
`endif
    {carry, sum} = {1'b0, acc} + {1'b0, inc};
    // Writes always restart the written channel so its new rate starts in phase.
    clr     = i_sync | i_wr | (mode == MODE_OFF) | (mode == MODE_ON);
    acc_nx  = clr ? '0 : sum;
    wrap_nx = clr ? 1'b0 : carry;
    case (mode_nx)
      MODE_OFF: out_nx = 1'b0;
      MODE_ON:  out_nx = 1'b1;
`ifdef MULTI_BLINKER_PWM_EN
      MODE_PWM: out_nx = (acc_nx[WIDTH-1 -: 8] < duty_nx);
`endif
      default:  out_nx = acc_nx[WIDTH-1];
    endcase
  end

  // Channel state and registered outputs, async reset to a ~1 Hz blink.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc    <= '0;
      mode   <= MODE_BLINK;
      inc    <= DEFAULT_INC;
      o_out  <= 1'b0;
      o_wrap <= 1'b0;
    end else begin
      acc    <= acc_nx;
      mode   <= mode_nx;
      inc    <= inc_nx;
      o_out  <= out_nx;
      o_wrap <= wrap_nx;
    end
  end

`ifdef MULTI_BLINKER_PWM_EN
  // Duty threshold register, only present when PWM is built.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) duty <= 8'h80;
    else       duty <= duty_nx;
  end
`endif
endmodule

module multi_blinker #(
  parameter int               CHANNELS      = 4,
  parameter int               WIDTH         = 32,
  parameter int unsigned      CLOCK_RATE_HZ = 100_000_000,
  parameter logic [WIDTH-1:0] DEFAULT_INC   =
    WIDTH'((64'd1 << (WIDTH-2)) / 64'(CLOCK_RATE_HZ / 4)),
  localparam int              CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_sync,
  input  logic                i_wr_en,
  input  logic [CH_W-1:0]     i_wr_ch,
  input  logic [1:0]          i_wr_mode,
  input  logic [WIDTH-1:0]    i_wr_inc,
  input  logic [7:0]          i_wr_duty,
  output logic [CHANNELS-1:0] o_out,
  output logic [CHANNELS-1:0] o_wrap
);
  logic [CHANNELS-1:0] wr_sel;

  // Out-of-range channel indices match no lane, so such writes are dropped.
  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    assign wr_sel[n] = i_wr_en && (i_wr_ch == CH_W'(n));

    multi_blinker_ch #(
      .WIDTH       (WIDTH),
      .DEFAULT_INC (DEFAULT_INC)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_sync    (i_sync),
      .i_wr      (wr_sel[n]),
      .i_wr_mode (i_wr_mode),
      .i_wr_inc  (i_wr_inc),
      .i_wr_duty (i_wr_duty),
      .o_out     (o_out[n]),
      .o_wrap    (o_wrap[n])
    );
  end
endmodule

// File: tb/tb_multi_blinker.sv
// Bench for multi_blinker: WIDTH=8 builds with 4 and 5 channels, a behavioural
// model checked every cycle, directed scenarios with literal expectations,
// then randomized writes and syncs.
module tb_multi_blinker;
  localparam int W   = 8;
  localparam int CLK = 16;
  localparam int DEF = (1 << (W-2)) / (CLK / 4);   // 16

  logic       clk = 0, rst = 1, sync = 0;
  logic       w4_en = 0, w5_en = 0;
  logic [1:0] w4_ch = '0;
  logic [2:0] w5_ch = '0;
  logic [1:0] wmode = '0;
  logic [7:0] winc = '0, wduty = '0;
  logic [3:0] o4_out, o4_wrap;
  logic [4:0] o5_out, o5_wrap;

  int total = 0, bad = 0;

  // model state: [dut][channel]
  int         m_acc  [2][5];
  int         m_mode [2][5];
  int         m_inc  [2][5];
  int         m_duty [2][5];
  logic [4:0] exp_out  [2];
  logic [4:0] exp_wrap [2];

  multi_blinker #(.CHANNELS(4), .WIDTH(W), .CLOCK_RATE_HZ(CLK)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_sync(sync), .i_wr_en(w4_en), .i_wr_ch(w4_ch),
    .i_wr_mode(wmode), .i_wr_inc(winc), .i_wr_duty(wduty),
    .o_out(o4_out), .o_wrap(o4_wrap));

  multi_blinker #(.CHANNELS(5), .WIDTH(W), .CLOCK_RATE_HZ(CLK)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_sync(sync), .i_wr_en(w5_en), .i_wr_ch(w5_ch),
    .i_wr_mode(wmode), .i_wr_inc(winc), .i_wr_duty(wduty),
    .o_out(o5_out), .o_wrap(o5_wrap));

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  function automatic bit f_out(int md, int a, int dt);
`ifdef MULTI_BLINKER_PWM_EN
    if (md == 3) return a < dt;
`endif
    if (md == 0) return 1'b0;
    if (md == 1) return 1'b1;
    return a >= 128;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 5; c++) begin
        m_acc[d][c] = 0; m_mode[d][c] = 2; m_inc[d][c] = DEF; m_duty[d][c] = 128;
      end
      exp_out[d] = '0; exp_wrap[d] = '0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < ((d == 0) ? 4 : 5); c++) begin
        bit wr;
        int s;
        wr = (d == 0) ? (w4_en && int'(w4_ch) == c) : (w5_en && int'(w5_ch) == c);
        if (wr) begin
          m_mode[d][c] = int'(wmode); m_inc[d][c] = int'(winc); m_duty[d][c] = int'(wduty);
        end
        if (sync || wr || m_mode[d][c] < 2) begin
          m_acc[d][c] = 0; exp_wrap[d][c] = 1'b0;
        end else begin
          s = m_acc[d][c] + m_inc[d][c];
          exp_wrap[d][c] = (s > 255);
          m_acc[d][c] = s % 256;
        end
        exp_out[d][c] = f_out(m_mode[d][c], m_acc[d][c], m_duty[d][c]);
      end
    end
  endtask

  // reference model, advanced on the same events as the DUT
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("out4",  int'(o4_out),  int'(exp_out[0][3:0]));
      chk("wrap4", int'(o4_wrap), int'(exp_wrap[0][3:0]));
      chk("out5",  int'(o5_out),  int'(exp_out[1]));
      chk("wrap5", int'(o5_wrap), int'(exp_wrap[1]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr4(int ch, int md, int inc, int dt);
    w4_en = 1; w4_ch = 2'(ch); wmode = 2'(md); winc = 8'(inc); wduty = 8'(dt);
    tick();
    w4_en = 0;
  endtask

  initial begin
    int h, w, k;
    logic [4:0] seen;
    repeat (2) tick();
    chk("rst_out", int'(o4_out), 0);
    #2 rst = 0;

    // after release ch0 blinks at the default rate: 8 high + 1 wrap per 16
    h = 0; w = 0;
    repeat (16) begin tick(); h += int'(o4_out[0]); w += int'(o4_wrap[0]); end
    chk("def_blink_hi", h, 8);
    chk("def_blink_wrap", w, 1);

    // async reset while outputs are high
    k = 0;
    while (o4_out[0] !== 1'b1 && k < 32) begin tick(); k++; end
    chk("pre_rst_high", int'(o4_out[0]), 1);
    #2 rst = 1;
    #1 chk("async_rst_out", int'(o4_out), 0);
    chk("async_rst_wrap", int'(o4_wrap), 0);
    chk("async_rst_out5", int'(o5_out), 0);
    tick(); tick();
    #2 rst = 0;
    tick();

    // BLINK ch1 inc 16: low 8, high 8, wrap on the falling edge
    wr4(1, 2, 16, 0);
    for (int i = 0; i < 32; i++) begin
      chk("blink_out1",  int'(o4_out[1]),  int'((i % 16) >= 8));
      chk("blink_wrap1", int'(o4_wrap[1]), int'(i > 0 && (i % 16) == 0));
      tick();
    end

    // PWM ch2 duty 0x40, then duty 0
    wr4(2, 3, 16, 8'h40);
    h = 0;
    repeat (16) begin h += int'(o4_out[2]); tick(); end
`ifdef MULTI_BLINKER_PWM_EN
    chk("pwm_40_hi", h, 4);
`else
    chk("pwm_40_hi", h, 8);
`endif
    wr4(2, 3, 16, 0);
    h = 0;
    repeat (16) begin h += int'(o4_out[2]); tick(); end
`ifdef MULTI_BLINKER_PWM_EN
    chk("pwm_00_hi", h, 0);
`else
    chk("pwm_00_hi", h, 8);
`endif

    // OFF then ON on ch3, never wrapping
    wr4(3, 0, 16, 0);
    h = 0; w = 0;
    repeat (20) begin h += int'(o4_out[3]); w += int'(o4_wrap[3]); tick(); end
    chk("off_hi", h, 0);
    chk("off_wrap", w, 0);
    wr4(3, 1, 16, 0);
    h = 0; w = 0;
    repeat (20) begin h += int'(o4_out[3]); w += int'(o4_wrap[3]); tick(); end
    chk("on_hi", h, 20);
    chk("on_wrap", w, 0);

    // out-of-range channel on the 5-channel build changes nothing
    w5_en = 1; w5_ch = 3'd5; wmode = 2'd0; winc = 8'd0;
    tick();
    w5_en = 0;
    seen = '0;
    repeat (16) begin seen |= o5_wrap; tick(); end
    chk("invalid_ch_wraps", int'(seen), 31);

    // sync together with a write of ch1 at inc 32
    wr4(0, 2, 16, 0);
    repeat (5) tick();
    wr4(1, 2, 16, 0);
    repeat (3) tick();
    sync = 1; w4_en = 1; w4_ch = 2'd1; wmode = 2'd2; winc = 8'd32;
    tick();
    sync = 0; w4_en = 0;
    for (int i = 0; i <= 16; i++) begin
      chk("sync_out0",  int'(o4_out[0]),  int'((i % 16) >= 8));
      chk("sync_out1",  int'(o4_out[1]),  int'((i % 8) >= 4));
      chk("sync_wrap0", int'(o4_wrap[0]), int'(i == 16));
      chk("sync_wrap1", int'(o4_wrap[1]), int'(i == 8 || i == 16));
      tick();
    end

    // randomized traffic, checked by the model every cycle
    repeat (3000) begin
      sync  = ($urandom_range(0, 31) == 0);
      w4_en = ($urandom_range(0, 3) == 0);
      w4_ch = 2'($urandom_range(0, 3));
      w5_en = ($urandom_range(0, 3) == 0);
      w5_ch = 3'($urandom_range(0, 7));
      wmode = 2'($urandom_range(0, 3));
      winc  = $urandom_range(0, 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      wduty = 8'($urandom_range(0, 255));
      tick();
    end
    sync = 0; w4_en = 0; w5_en = 0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
